// File: rtl/edge_monitor_defs.sv
// Shared definitions for edge_monitor: debounce FSM encodings and counter saturation helper.
package edge_monitor_defs;

  typedef enum logic [1:0] {
    S_LOW    = 2'd0,
    S_CHK_HI = 2'd1,
    S_HIGH   = 2'd2,
    S_CHK_LO = 2'd3
  } state_e;

  // All-ones value of a width-bit counter; widths of 32 and above clamp to 32 bits.
  function automatic logic [31:0] sat_max(input int unsigned width);
    if (width >= 32) begin
      return 32'hFFFF_FFFF;
    end
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain multi-flop synchroniser for a single-bit level; output is the last stage.
module sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/edge_monitor.sv
// Synchronise and debounce a 1-bit level, then report edges, a rise count and last high width.
module edge_monitor
  import edge_monitor_defs::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             din,
  input  logic             en,
  input  logic             clr,
  output logic             dout,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] hi_width,
  output logic             width_vld
);

  localparam int unsigned DebW = $clog2(DEB_CYCLES);
  localparam logic [DebW-1:0]  DebLast = DebW'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax  = CNT_W'(sat_max(CNT_W));

  logic sync;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rstn(rstn),
    .d   (din),
    .q   (sync)
  );

  state_e            state_q, state_d;
  logic [DebW-1:0]   deb_cnt_q, deb_cnt_d;
  logic              dout_q, dout_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic [CNT_W-1:0]  rise_cnt_q, rise_cnt_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  hi_width_q, hi_width_d;
  logic              width_vld_q, width_vld_d;

  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    dout_d    = dout_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    case (state_q)
      S_LOW: begin
        if (sync) begin
          state_d   = S_CHK_HI;
          deb_cnt_d = DebW'(1);
        end
      end
      S_CHK_HI: begin
        if (!sync) begin
          state_d = S_LOW;
        end else if (deb_cnt_q == DebLast) begin
          state_d = S_HIGH;
          dout_d  = 1'b1;
          rise_d  = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + DebW'(1);
        end
      end
      S_HIGH: begin
        if (!sync) begin
          state_d   = S_CHK_LO;
          deb_cnt_d = DebW'(1);
        end
      end
      S_CHK_LO: begin
        if (sync) begin
          state_d = S_HIGH;
        end else if (deb_cnt_q == DebLast) begin
          state_d = S_LOW;
          dout_d  = 1'b0;
          fall_d  = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + DebW'(1);
        end
      end
      default: state_d = S_LOW;
    endcase
  end

  // Counters act on the edge that launches rise/fall, so width_vld lines up with fall.
  always_comb begin
    rise_cnt_d  = rise_cnt_q;
    wcnt_d      = wcnt_q;
    hi_width_d  = hi_width_q;
    width_vld_d = 1'b0;
    if (clr) begin
      rise_cnt_d = '0;
      wcnt_d     = '0;
      hi_width_d = '0;
    end else begin
      if (rise_d && en && (rise_cnt_q != CntMax)) begin
        rise_cnt_d = rise_cnt_q + CNT_W'(1);
      end
      if (rise_d) begin
        wcnt_d = '0;
      end else if (dout_q && (wcnt_q != CntMax)) begin
        wcnt_d = wcnt_q + CNT_W'(1);
      end
      // The falling-edge cycle is the last high cycle, so it is counted here.
      if (fall_d) begin
        hi_width_d  = (wcnt_q == CntMax) ? CntMax : wcnt_q + CNT_W'(1);
        width_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_LOW;
      deb_cnt_q   <= '0;
      dout_q      <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      rise_cnt_q  <= '0;
      wcnt_q      <= '0;
      hi_width_q  <= '0;
      width_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      dout_q      <= dout_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      rise_cnt_q  <= rise_cnt_d;
      wcnt_q      <= wcnt_d;
      hi_width_q  <= hi_width_d;
      width_vld_q <= width_vld_d;
    end
  end

  assign dout      = dout_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign rise_cnt  = rise_cnt_q;
  assign hi_width  = hi_width_q;
  assign width_vld = width_vld_q;

endmodule

// File: tb/tb_edge_monitor.sv
// Directed bench for edge_monitor: default instance plus a CNT_W=3 instance for saturation.
module tb_edge_monitor;

  logic       clk = 1'b0;
  logic       rstn, din, en, clr;
  logic       dout, rise, fall, width_vld;
  logic [7:0] rise_cnt, hi_width;
  logic       din3, en3, clr3;
  logic       dout3, rise3, fall3, width_vld3;
  logic [2:0] rise_cnt3, hi_width3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  edge_monitor dut (
    .clk(clk), .rstn(rstn), .din(din), .en(en), .clr(clr),
    .dout(dout), .rise(rise), .fall(fall), .rise_cnt(rise_cnt),
    .hi_width(hi_width), .width_vld(width_vld)
  );

  edge_monitor #(.CNT_W(3)) dut3 (
    .clk(clk), .rstn(rstn), .din(din3), .en(en3), .clr(clr3),
    .dout(dout3), .rise(rise3), .fall(fall3), .rise_cnt(rise_cnt3),
    .hi_width(hi_width3), .width_vld(width_vld3)
  );

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    step(3);
    vectors++; if (dout !== 1'b0) begin miscompares++; $display("FAIL rst_dout got %b want 0", dout); end
    vectors++; if (rise !== 1'b0) begin miscompares++; $display("FAIL rst_rise got %b want 0", rise); end
    vectors++; if (fall !== 1'b0) begin miscompares++; $display("FAIL rst_fall got %b want 0", fall); end
    vectors++; if (rise_cnt !== 8'd0) begin miscompares++; $display("FAIL rst_cnt got %0d want 0", rise_cnt); end
    vectors++; if (hi_width !== 8'd0) begin miscompares++; $display("FAIL rst_width got %0d want 0", hi_width); end
    vectors++; if (width_vld !== 1'b0) begin miscompares++; $display("FAIL rst_vld got %b want 0", width_vld); end
    rstn = 1'b1;
    step(5);
    vectors++; if (rise !== 1'b0) begin miscompares++; $display("FAIL rst_rise_early got %b want 0", rise); end
    step(1);
    vectors++; if (rise !== 1'b1) begin miscompares++; $display("FAIL rst_rise_6 got %b want 1", rise); end
    vectors++; if (dout !== 1'b1) begin miscompares++; $display("FAIL rst_dout_6 got %b want 1", dout); end
    step(1);
    vectors++; if (rise !== 1'b0) begin miscompares++; $display("FAIL rst_rise_once got %b want 0", rise); end
    vectors++; if (rise_cnt !== 8'd1) begin miscompares++; $display("FAIL rst_cnt_1 got %0d want 1", rise_cnt); end
    din = 1'b0;
    step(12);
  endtask

  task automatic test_clean_edge;
    din = 1'b1;
    step(5);
    vectors++; if (dout !== 1'b0) begin miscompares++; $display("FAIL clean_dout_5 got %b want 0", dout); end
    step(1);
    vectors++; if (rise !== 1'b1 || dout !== 1'b1) begin
      miscompares++; $display("FAIL clean_rise_6 got rise=%b dout=%b want 1 1", rise, dout); end
    step(1);
    vectors++; if (rise !== 1'b0) begin miscompares++; $display("FAIL clean_rise_once got %b want 0", rise); end
    vectors++; if (rise_cnt !== 8'd2) begin miscompares++; $display("FAIL clean_cnt got %0d want 2", rise_cnt); end
    step(13);
    din = 1'b0;
    step(5);
    vectors++; if (fall !== 1'b0 || dout !== 1'b1) begin
      miscompares++; $display("FAIL clean_fall_5 got fall=%b dout=%b want 0 1", fall, dout); end
    step(1);
    vectors++; if (fall !== 1'b1 || dout !== 1'b0 || rise !== 1'b0) begin
      miscompares++; $display("FAIL clean_fall_6 got fall=%b dout=%b rise=%b want 1 0 0", fall, dout, rise); end
    vectors++; if (width_vld !== 1'b1 || hi_width !== 8'd20) begin
      miscompares++; $display("FAIL clean_width got vld=%b w=%0d want 1 20", width_vld, hi_width); end
    step(1);
    vectors++; if (fall !== 1'b0 || width_vld !== 1'b0) begin
      miscompares++; $display("FAIL clean_fall_once got fall=%b vld=%b want 0 0", fall, width_vld); end
    step(4);
  endtask

  task automatic test_glitch;
    din = 1'b1;
    step(3);
    din = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      vectors++; if (rise !== 1'b0 || dout !== 1'b0) begin
        miscompares++; $display("FAIL glitch_hi_%0d got rise=%b dout=%b want 0 0", i, rise, dout); end
    end
    vectors++; if (rise_cnt !== 8'd2) begin miscompares++; $display("FAIL glitch_cnt got %0d want 2", rise_cnt); end
    din = 1'b1;
    step(10);
    din = 1'b0;
    step(3);
    din = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      vectors++; if (fall !== 1'b0 || dout !== 1'b1) begin
        miscompares++; $display("FAIL glitch_lo_%0d got fall=%b dout=%b want 0 1", i, fall, dout); end
    end
    din = 1'b0;
    step(10);
    vectors++; if (rise_cnt !== 8'd3) begin miscompares++; $display("FAIL glitch_cnt2 got %0d want 3", rise_cnt); end
    vectors++; if (hi_width !== 8'd23) begin miscompares++; $display("FAIL glitch_width got %0d want 23", hi_width); end
  endtask

  task automatic test_width;
    din = 1'b1;
    step(7);
    din = 1'b0;
    step(5);
    vectors++; if (width_vld !== 1'b0) begin miscompares++; $display("FAIL width_vld_early got %b want 0", width_vld); end
    step(1);
    vectors++; if (fall !== 1'b1 || width_vld !== 1'b1 || hi_width !== 8'd7) begin
      miscompares++; $display("FAIL width_load got fall=%b vld=%b w=%0d want 1 1 7", fall, width_vld, hi_width); end
    step(1);
    vectors++; if (width_vld !== 1'b0 || hi_width !== 8'd7) begin
      miscompares++; $display("FAIL width_hold got vld=%b w=%0d want 0 7", width_vld, hi_width); end
    step(4);
  endtask

  task automatic test_enable;
    logic saw_rise;
    saw_rise = 1'b0;
    en = 1'b0;
    din = 1'b1;
    for (int i = 0; i < 8; i++) begin step(1); saw_rise |= rise; end
    din = 1'b0;
    for (int i = 0; i < 10; i++) begin step(1); saw_rise |= rise; end
    en = 1'b1;
    vectors++; if (saw_rise !== 1'b1) begin miscompares++; $display("FAIL en_rise got %b want 1", saw_rise); end
    vectors++; if (rise_cnt !== 8'd4) begin miscompares++; $display("FAIL en_cnt got %0d want 4", rise_cnt); end
    vectors++; if (hi_width !== 8'd8) begin miscompares++; $display("FAIL en_width got %0d want 8", hi_width); end
  endtask

  task automatic test_clr_priority;
    din = 1'b1;
    step(5);
    clr = 1'b1;
    step(1);
    vectors++; if (rise !== 1'b1 || dout !== 1'b1) begin
      miscompares++; $display("FAIL clr_rise got rise=%b dout=%b want 1 1", rise, dout); end
    vectors++; if (rise_cnt !== 8'd0 || hi_width !== 8'd0) begin
      miscompares++; $display("FAIL clr_counts got cnt=%0d w=%0d want 0 0", rise_cnt, hi_width); end
    clr = 1'b0;
    step(1);
    vectors++; if (rise_cnt !== 8'd0) begin miscompares++; $display("FAIL clr_cnt_after got %0d want 0", rise_cnt); end
    step(8);
    din = 1'b0;
    step(10);
    vectors++; if (hi_width !== 8'd15) begin miscompares++; $display("FAIL clr_width got %0d want 15", hi_width); end
    din = 1'b1;
    step(6);
    din = 1'b0;
    step(10);
    vectors++; if (rise_cnt !== 8'd1 || hi_width !== 8'd6) begin
      miscompares++; $display("FAIL clr_next got cnt=%0d w=%0d want 1 6", rise_cnt, hi_width); end
  endtask

  task automatic test_reset_mid_check;
    din = 1'b1;
    step(3);
    #2 rstn = 1'b0;
    #1;
    vectors++; if (dout !== 1'b0 || rise !== 1'b0) begin
      miscompares++; $display("FAIL mid_async_out got dout=%b rise=%b want 0 0", dout, rise); end
    vectors++; if (rise_cnt !== 8'd0 || hi_width !== 8'd0) begin
      miscompares++; $display("FAIL mid_async_cnt got cnt=%0d w=%0d want 0 0", rise_cnt, hi_width); end
    din = 1'b0;
    step(2);
    rstn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1);
      vectors++; if (rise !== 1'b0 || dout !== 1'b0) begin
        miscompares++; $display("FAIL mid_nopulse_%0d got rise=%b dout=%b want 0 0", i, rise, dout); end
    end
  endtask

  task automatic test_saturation;
    logic saw_rise3;
    for (int i = 0; i < 9; i++) begin
      din3 = 1'b1; step(6);
      din3 = 1'b0; step(8);
    end
    vectors++; if (rise_cnt3 !== 3'd7) begin miscompares++; $display("FAIL sat_cnt got %0d want 7", rise_cnt3); end
    vectors++; if (hi_width3 !== 3'd6) begin miscompares++; $display("FAIL sat_w6 got %0d want 6", hi_width3); end
    din3 = 1'b1; step(12);
    din3 = 1'b0; step(5);
    step(1);
    vectors++; if (fall3 !== 1'b1 || width_vld3 !== 1'b1 || dout3 !== 1'b0) begin
      miscompares++; $display("FAIL sat_fall got fall=%b vld=%b dout=%b want 1 1 0", fall3, width_vld3, dout3); end
    vectors++; if (hi_width3 !== 3'd7) begin miscompares++; $display("FAIL sat_width got %0d want 7", hi_width3); end
    step(2);
    en3 = 1'b0;
    din3 = 1'b1; step(6);
    din3 = 1'b0; step(8);
    vectors++; if (rise_cnt3 !== 3'd7) begin miscompares++; $display("FAIL sat_en0 got %0d want 7", rise_cnt3); end
    clr3 = 1'b1; step(1); clr3 = 1'b0;
    vectors++; if (rise_cnt3 !== 3'd0 || hi_width3 !== 3'd0) begin
      miscompares++; $display("FAIL sat_clr got cnt=%0d w=%0d want 0 0", rise_cnt3, hi_width3); end
    saw_rise3 = 1'b0;
    din3 = 1'b1;
    for (int i = 0; i < 6; i++) begin step(1); saw_rise3 |= rise3; end
    din3 = 1'b0; step(8);
    vectors++; if (saw_rise3 !== 1'b1 || rise_cnt3 !== 3'd0) begin
      miscompares++; $display("FAIL sat_en0_clr got rise=%b cnt=%0d want 1 0", saw_rise3, rise_cnt3); end
    en3 = 1'b1;
    din3 = 1'b1; step(6);
    din3 = 1'b0; step(8);
    vectors++; if (rise_cnt3 !== 3'd1) begin miscompares++; $display("FAIL sat_en1 got %0d want 1", rise_cnt3); end
  endtask

  initial begin
    rstn = 1'b0; din = 1'b1; en = 1'b1; clr = 1'b0;
    din3 = 1'b0; en3 = 1'b1; clr3 = 1'b0;
    test_reset();
    test_clean_edge();
    test_glitch();
    test_width();
    test_enable();
    test_clr_priority();
    test_reset_mid_check();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
